// File: rtl/la_pkg.sv
// Shared constants, stage state encoding and packet field helpers for the
// logic-analyser RLE trace decoder.
package la_pkg;

  localparam int              LA_DATA_W   = 24;
  localparam int              LA_RC_W     = 8;
  localparam logic [7:0]      LA_RC_MAX   = 8'hFF;
  localparam logic [31:0]     LA_NULL_PKT = 32'h0;

  // A stage either sits empty or is expanding a packet into samples.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } stage_state_e;

  // Repeat count lives in the top byte of a trace packet.
  function automatic logic [LA_RC_W-1:0] la_pkt_rc(input logic [31:0] pkt);
    return pkt[31 -: LA_RC_W];
  endfunction

  // Sample value lives in the low bits of a trace packet.
  function automatic logic [LA_DATA_W-1:0] la_pkt_data(input logic [31:0] pkt);
    return pkt[LA_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/la_rle_stage.sv
// One packet slot of the decoder: holds sample value, remaining repeat count,
// null/last flags and an IDLE/EXPAND state. Used for both the current
// (expanding) slot and the one-entry prefetch slot.
module la_rle_stage
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W,
  parameter int RC_W   = LA_RC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              drop,
  input  logic              dec,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RC_W-1:0]   ld_rem,
  input  logic              ld_null,
  input  logic              ld_last,
  output logic [DATA_W-1:0] data_q,
  output logic [RC_W-1:0]   rem_q,
  output logic              null_q,
  output logic              last_q,
  output logic              valid
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] data_d;
  logic [RC_W-1:0]   rem_d;
  logic              null_d;
  logic              last_d;

  // Next-state: flush beats load, load beats drop, drop beats decrement.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    null_d  = null_q;
    last_d  = last_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_EXPAND;
      data_d  = ld_data;
      rem_d   = ld_rem;
      null_d  = ld_null;
      last_d  = ld_last;
    end else if (drop) begin
      state_d = ST_IDLE;
    end else if (dec) begin
      rem_d   = rem_q - RC_W'(1);
    end
  end

  // Slot registers, cleared asynchronously so no partial packet survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      null_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      null_q  <= null_d;
      last_q  <= last_d;
    end
  end

  assign valid = (state_q == ST_EXPAND);

endmodule

// File: rtl/la_rle_decoder.sv
// Run-length trace decoder: accepts {rc, data} packets on an AXI-stream style
// input and expands each into rc samples. A current slot expands while a
// one-entry prefetch slot absorbs the next packet so packets flow without
// bubbles. dec_enable low flushes both slots on the next edge.
module la_rle_decoder
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W,
  parameter int RC_W   = LA_RC_W
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic [31:0]       s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [1:0]        s_tuser,
  input  logic              dec_enable,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  output logic              smp_unknown,
  output logic              smp_last,
  input  logic              smp_ready,
  output logic [31:0]       sample_cnt,
  output logic [15:0]       null_cnt,
  output logic              fmt_err,
  input  logic              err_clr
);

  // Packet decode
  logic [RC_W-1:0]   pkt_rc;
  logic [DATA_W-1:0] pkt_data;
  logic [RC_W-1:0]   pkt_rem;
  logic              pkt_null;
  logic              pkt_bad;

  // Slot outputs
  logic [DATA_W-1:0] cur_data, hold_data;
  logic [RC_W-1:0]   cur_rem, hold_rem;
  logic              cur_null, hold_null;
  logic              cur_last, hold_last;
  logic              cur_valid, hold_valid;

  // Slot controls
  logic              flush;
  logic              accept;
  logic              smp_hs;
  logic              cur_fin;
  logic              cur_from_hold;
  logic              cur_from_pkt;
  logic              cur_load;
  logic              hold_load;
  logic              hold_valid_next;
  logic [DATA_W-1:0] cur_ld_data;
  logic [RC_W-1:0]   cur_ld_rem;
  logic              cur_ld_null;
  logic              cur_ld_last;

  // Registered status
  logic              s_tready_q, s_tready_d;
  logic [31:0]       sample_cnt_q, sample_cnt_d;
  logic [15:0]       null_cnt_q, null_cnt_d;
  logic              fmt_err_q, fmt_err_d;

  // Sideband user bits carry nothing for this decoder.
  logic              unused_tuser;
  assign unused_tuser = ^s_tuser;

  // A null packet and a malformed rc=0 packet both collapse to a single sample.
  assign pkt_rc   = s_tdata[31 -: RC_W];
  assign pkt_data = s_tdata[DATA_W-1:0];
  assign pkt_null = (s_tdata == LA_NULL_PKT);
  assign pkt_bad  = (pkt_rc == '0) && !pkt_null;
  assign pkt_rem  = (pkt_rc == '0) ? RC_W'(1) : pkt_rc;

  assign flush   = ~dec_enable;
  assign accept  = s_tvalid & s_tready_q;
  assign smp_hs  = cur_valid & smp_ready;
  assign cur_fin = smp_hs & (cur_rem == RC_W'(1));

  // Slot steering: s_tready only rises with hold empty, so an accepted packet
  // goes straight to the current slot when it is free, otherwise to hold.
  always_comb begin
    cur_from_hold   = cur_fin & hold_valid;
    cur_from_pkt    = accept & ~hold_valid & (~cur_valid | cur_fin);
    cur_load        = cur_from_hold | cur_from_pkt;
    hold_load       = accept & ~cur_from_pkt;
    hold_valid_next = dec_enable & (hold_load | (hold_valid & ~cur_from_hold));
    cur_ld_data     = cur_from_hold ? hold_data : pkt_data;
    cur_ld_rem      = cur_from_hold ? hold_rem  : pkt_rem;
    cur_ld_null     = cur_from_hold ? hold_null : pkt_null;
    cur_ld_last     = cur_from_hold ? hold_last : s_tlast;
  end

  la_rle_stage #(
    .DATA_W (DATA_W),
    .RC_W   (RC_W)
  ) u_cur (
    .clk     (axis_clk),
    .rst_n   (axis_rst_n),
    .flush   (flush),
    .load    (cur_load),
    .drop    (cur_fin),
    .dec     (smp_hs),
    .ld_data (cur_ld_data),
    .ld_rem  (cur_ld_rem),
    .ld_null (cur_ld_null),
    .ld_last (cur_ld_last),
    .data_q  (cur_data),
    .rem_q   (cur_rem),
    .null_q  (cur_null),
    .last_q  (cur_last),
    .valid   (cur_valid)
  );

  la_rle_stage #(
    .DATA_W (DATA_W),
    .RC_W   (RC_W)
  ) u_hold (
    .clk     (axis_clk),
    .rst_n   (axis_rst_n),
    .flush   (flush),
    .load    (hold_load),
    .drop    (cur_from_hold),
    .dec     (1'b0),
    .ld_data (pkt_data),
    .ld_rem  (pkt_rem),
    .ld_null (pkt_null),
    .ld_last (s_tlast),
    .data_q  (hold_data),
    .rem_q   (hold_rem),
    .null_q  (hold_null),
    .last_q  (hold_last),
    .valid   (hold_valid)
  );

  // Ready, counters and sticky error: counters freeze while disabled,
  // err_clr overrides a same-cycle error set.
  always_comb begin
    s_tready_d   = dec_enable & ~hold_valid_next;
    sample_cnt_d = sample_cnt_q;
    null_cnt_d   = null_cnt_q;
    fmt_err_d    = fmt_err_q;
    if (dec_enable && smp_hs && (sample_cnt_q != '1)) begin
      sample_cnt_d = sample_cnt_q + 32'd1;
    end
    if (dec_enable && accept && pkt_null && (null_cnt_q != '1)) begin
      null_cnt_d = null_cnt_q + 16'd1;
    end
    if (err_clr) begin
      fmt_err_d = 1'b0;
    end else if (dec_enable && accept && pkt_bad) begin
      fmt_err_d = 1'b1;
    end
  end

  // Status registers with asynchronous reset.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      s_tready_q   <= 1'b0;
      sample_cnt_q <= '0;
      null_cnt_q   <= '0;
      fmt_err_q    <= 1'b0;
    end else begin
      s_tready_q   <= s_tready_d;
      sample_cnt_q <= sample_cnt_d;
      null_cnt_q   <= null_cnt_d;
      fmt_err_q    <= fmt_err_d;
    end
  end

  assign s_tready    = s_tready_q;
  assign smp_valid   = cur_valid;
  assign smp_data    = cur_data;
  assign smp_unknown = cur_valid & cur_null;
  assign smp_last    = cur_valid & cur_last & (cur_rem == RC_W'(1));
  assign sample_cnt  = sample_cnt_q;
  assign null_cnt    = null_cnt_q;
  assign fmt_err     = fmt_err_q;

endmodule

// File: doc/la_rle_decoder.md
LA_RLE_DECODER -- requirements
Module: la_rle_decoder

Interface
REQ-001 The block SHALL have parameters DATA_W, default 24, sample width.
REQ-002 The block SHALL have parameters RC_W, default 8, repeat-count width; DATA_W+RC_W=32.
REQ-003 The block SHALL have these ports, with one clock; reset is asynchronous and active-low:
- axis_clk  in  1  sole clock.
- axis_rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  32  trace packet {rc[31:24], data[23:0]}.
- s_tvalid  in  1  packet valid.
- s_tready  out  1  packet accept.
- s_tlast  in  1  end of AXIS burst.
- s_tuser  in  2  ignored.
- dec_enable  in  1  decoder enable; low = synchronous flush.
- smp_data  out  DATA_W  expanded sample.
- smp_valid  out  1  sample valid.
- smp_unknown  out  1  sample is 'x' (from null packet).
- smp_last  out  1  final sample of a packet received with s_tlast.
- smp_ready  in  1  sample consumer ready.
- sample_cnt  out  32  samples emitted, saturating.
- null_cnt  out  16  null packets received, saturating.
- fmt_err  out  1  sticky: packet with rc=0 and data!=0.
- err_clr  in  1  clears fmt_err.

Function
REQ-004 The block SHALL make packet handshake s_tvalid&s_tready.
REQ-005 The block SHALL make sample handshake smp_valid&smp_ready.
REQ-006 The block SHALL drive s_tready = dec_enable & !hold_valid, registered-state only, with no combinational path from s_tvalid.
REQ-007 The block SHALL hold datapath = current stage (cur_data, cur_rem[RC_W-1:0], cur_null, cur_last, cur_valid) plus one-entry prefetch buffer (hold_*).
REQ-008 The block SHALL run a state machine per current stage: IDLE (cur_valid=0) and EXPAND (cur_valid=1).
REQ-009 The block SHALL load an accepted packet into the current stage when the current stage is empty or finishing this cycle, else into hold; SHALL load the current stage from hold when the current stage finishes and hold_valid=1.
REQ-010 The block SHALL assert smp_valid the cycle after acceptance when the pipeline is empty (latency 1).
REQ-011 The block SHALL pass back-to-back packets with zero bubble.
REQ-012 The block SHALL expand a normal packet (rc 1..255) into rc samples of data, smp_unknown=0.
REQ-013 The block SHALL decrement cur_rem on each sample handshake; the packet finishes on handshake with cur_rem=1.
REQ-014 The block SHALL expand a null packet (tdata=0) into exactly one sample with smp_unknown=1 and smp_data=0, and increment null_cnt.
REQ-015 The block SHALL treat rc=0 with data!=0 as one sample of data, and set fmt_err.
REQ-016 The block SHALL hold smp_data, smp_unknown and smp_last stable while smp_valid=1 and smp_ready=0.
REQ-017 The block SHALL assert smp_last only on the last sample of a packet accepted with s_tlast=1.
REQ-018 The block SHALL increment sample_cnt on every sample handshake and saturate it at 0xFFFFFFFF.
REQ-019 The block SHALL saturate null_cnt at 0xFFFF.
REQ-020 The block SHALL let err_clr win over a simultaneous fmt_err set.
REQ-021 On dec_enable=0, the block SHALL, next cycle, clear cur_valid and hold_valid, drive smp_valid=0 and s_tready=0, drop in-flight data, and hold counters and fmt_err.
REQ-022 The block SHALL leave packet acceptance and hold drain on a finishing cycle unaffected by smp_ready=0, which only stalls expansion.

Reset
REQ-023 axis_rst_n low SHALL asynchronously force smp_valid=0, s_tready=0, smp_data=0, smp_unknown=0, smp_last=0, sample_cnt=0, null_cnt=0, fmt_err=0, cur_valid=0, and hold_valid=0.
REQ-024 Reset asserted mid-expansion SHALL discard remaining samples, with no partial packet after release.
REQ-025 After reset release, s_tready SHALL rise on the first clock edge with dec_enable=1.

Structure
REQ-026 The shared la_pkg SHALL hold LA_DATA_W=24, LA_RC_W=8, LA_RC_MAX=8'hFF, LA_NULL_PKT=32'h0, and packet field-extract functions.
REQ-027 One sub-module SHALL be la_rle_stage (the register for one current/hold entry with load/clear), instantiated twice.

Verification
REQ-028 Packet 0x03_00ABCD, smp_ready=1 -> 3 samples 0x00ABCD on consecutive cycles starting 1 cycle after accept; sample_cnt=3.
REQ-029 Packets 0x01_000001, 0x02_000002 back-to-back, smp_ready=1 -> samples 1,2,2 with no gap; s_tready never low for more than the hold-full cycle.
REQ-030 Null packet 0x00000000 then 0x01_000005 with s_tlast -> one sample with smp_unknown=1, then 0x000005 with smp_last=1; null_cnt=1.
REQ-031 Packet 0xFF_123456 with smp_ready toggling 1/0 -> exactly 255 samples, data stable during stalls; a second packet waits in hold while s_tready=0.
REQ-032 Packet 0x00_000007 -> one sample 0x000007 and fmt_err=1; err_clr pulse -> fmt_err=0.
REQ-033 dec_enable dropped after 2 of 5 samples -> smp_valid=0 next cycle; re-enable with new packet 0x02_00000F -> exactly 2 samples; sample_cnt=4.
